// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    // All segments (and dp) dark on an active-low bus
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Bits needed to hold 0..slot_cyc-1 (at least one bit)
    function automatic int cnt_width(input int slot_cyc);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < slot_cyc) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD to common-anode 7-segment glyph, active-low {dp,g,f,e,d,c,b,a}.
// The dp bit is always off here; nibbles 10..15 give a dark digit.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Glyph lookup
    always_comb begin
        case (nibble)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Each slot starts with a dark dead-time, then lights one digit. Display
// data is double-buffered and only swapped at the frame boundary.
// Optional: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   com_n,
    output logic                    frame_done
);

    localparam int CW = cnt_width(SLOT_CYC);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   com_n_q, com_n_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    boundary;
    logic [3:0]              nibble_sel;
    logic                    dp_sel;
    logic [7:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lzb_mask;
    logic                    blank_sel;

    assign slot_end = (state_q != IDLE) && (cnt_q == CNT_LAST);
    assign boundary = enable && slot_end && (idx_q == IDX_LAST);

    assign nibble_sel = shadow_dig_q[{idx_q, 2'b00} +: 4];
    assign dp_sel     = shadow_dp_q[idx_q];

    seg7_decoder u_dec (
        .nibble (nibble_sel),
        .seg    (dec_seg)
    );

`ifdef SEG7_LZB_EN
    // Digit k>0 is dark when it and every higher digit of the shadow are zero
    always_comb begin
        logic zrun;
        lzb_mask = '0;
        zrun     = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zrun        = zrun & (shadow_dig_q[4*k +: 4] == 4'd0);
            lzb_mask[k] = zrun;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    assign blank_sel = lzb_mask[idx_q];

    // Slot sequencing: dead-time then on-time per digit, digit index wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (slot_end) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_d < BLANK_END) ? BLANK : ON;
        end
    end

    // Double buffer: pending collects loads, shadow swaps only at frame end
    always_comb begin
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (boundary) begin
            if (load) begin
                shadow_dig_d = digits_in;
                shadow_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                shadow_dig_d = pend_dig_q;
                shadow_dp_d  = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_dig_d   = digits_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    // Output drive for the next cycle; disabling darkens immediately
    always_comb begin
        seg_d        = SEG_OFF;
        com_n_d      = '1;
        frame_done_d = boundary;
        if (enable && (state_q == ON)) begin
            com_n_d[idx_q] = 1'b0;
            seg_d = (blank_sel ? SEG_OFF : dec_seg) & {~dp_sel, 7'h7F};
        end
    end

    // Sequencing and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_q        <= SEG_OFF;
            com_n_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            com_n_q      <= com_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Display data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign seg        = seg_q;
    assign com_n      = com_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus.
- Cycles a digit index and drives one active-low common line at a time.
- Feeds the selected nibble through one seg7_decoder instance and merges the decimal point.
- Inserts a blanking dead-time between digits to prevent ghosting. Double-buffers display data so a frame never tears.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits. Legal range 2..8.
- SLOT_CYC, 50000: clock cycles per digit slot (blank time plus on time).
- BLANK_CYC, 500: dead-time cycles at the start of each slot. Legal range 1..SLOT_CYC-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scanning on when 1
- load  in  1  single-cycle strobe: capture digits_in and dp_in
- digits_in  in  4*NUM_DIGITS  BCD nibbles; digit 0 in bits [3:0], least significant
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
- seg  out  8  segment bus, active-low; bit 7 = dp
- com_n  out  NUM_DIGITS  digit commons, active-low, one-hot-low when on
- frame_done  out  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset (asynchronous, rst_n=0):
  - seg=8'hFF, com_n all 1, frame_done=0.
  - idx=0, slot counter=0, state=IDLE.
  - Shadow, pending and pend_valid cleared (shadow digits 0, dp 0).
- States:
  - IDLE: outputs off. Goes to BLANK when enable=1.
  - BLANK: lasts BLANK_CYC cycles. seg=8'hFF, com_n all 1.
  - ON: lasts SLOT_CYC-BLANK_CYC cycles. com_n[idx]=0, others 1; seg=decode(shadow nibble idx) with bit7 = ~shadow_dp[idx].
- Slot counter:
  - Counts 0..SLOT_CYC-1. BLANK while cnt<BLANK_CYC, otherwise ON.
  - At cnt=SLOT_CYC-1: cnt returns to 0, idx increments, and idx wraps NUM_DIGITS-1 -> 0.
- Output timing: seg and com_n are registered and reflect the state/cnt/idx of the previous cycle, giving 1-cycle latency.
- frame_done: asserted for exactly one cycle, registered, on the cycle after the slot end with idx=NUM_DIGITS-1.
- Data buffering:
  - load=1 captures digits_in/dp_in into pending and sets pend_valid.
  - A later load before the boundary overwrites pending.
  - At the frame boundary (last slot end): if pend_valid, shadow<=pending and pend_valid is cleared.
  - Shadow never changes mid-frame.
  - load on the boundary cycle itself: shadow<=digits_in/dp_in directly, and pend_valid is cleared.
- enable=0 in any state: next cycle state=IDLE, cnt=0, idx=0, outputs off.
  - Pending data is retained.
  - No frame_done pulse.
  - On re-enable, scanning starts at BLANK of digit 0.
- Nibbles 10..15 decode to blank (8'hFF from the decoder); the dp is still honoured.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - During ON, digit k>0 shows blank segments (seg[6:0]=7'h7F) if the shadow nibbles k..NUM_DIGITS-1 are all 0.
  - The dp bit is unaffected.
  - Digit 0 is never blanked.
  - The blank mask is computed from shadow only, so it changes only at the frame boundary.
- Undefined: every digit is decoded normally.

Decomposition:
- Package seg7_pkg holds:
  - state enum {IDLE, BLANK, ON};
  - SEG_OFF=8'hFF;
  - a function computing the counter width from SLOT_CYC.
- One sub-module: seg7_decoder, instantiated once, combinational, driven by the muxed shadow nibble.
- All sequencing stays in seg7_scan_ctrl.

Test Plan (NUM_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2):
- Reset, then enable=1, shadow zero -> per slot: 2 cycles com_n=4'hF/seg=FF, then 6 cycles com_n=1110,1101,1011,0111 in turn with seg=8'hC0; frame_done high one cycle every 32 cycles.
- load digits_in=16'h4321, dp_in=4'b0010 mid-frame -> current frame unchanged; next frame digit0 seg=F9, digit1 seg=24 (A4 with dp low), digit2 B0, digit3 99.
- load asserted exactly on the boundary cycle with 16'h9876 -> the frame starting next shows 9876 with no frame of stale data.
- Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 is displayed from the next frame.
- enable dropped during the ON of digit 2 -> next cycle com_n=4'hF, seg=FF, no frame_done; re-enable -> starts at BLANK of digit 0. Also assert rst_n=0 asynchronously mid-ON -> outputs off in the same cycle.
- SEG7_LZB_EN defined, value 16'h0050 -> digit3 and digit2 blank (seg=FF), digit1 seg=92, digit0 seg=C0; value 16'h0000 -> only digit0 lit (C0).
